// File: rtl/fp_mul_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
// Default field widths give IEEE binary32.
package fp_mul_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
    } fp_flags_t;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN, right-aligned in a 64-bit word; callers slice to W.
    function automatic logic [63:0] qnan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
        r[man_w - 1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fp_mul_norm_round.sv
// Stage-3 normalise, round and pack for the FP multiplier (combinational).
// Rounding: RNE when FP_MUL_RNE_EN is defined, truncation otherwise.
module fp_mul_norm_round
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    localparam int W = 1 + EXP_W + MAN_W,
    localparam int PW = 2 * MAN_W + 2,
    localparam int XW = EXP_W + 2
) (
    input  logic                 sign,
    input  fp_class_e            cls,
    input  logic signed [XW-1:0] esum,
    input  logic [PW-1:0]        prod,
    output logic [W-1:0]         y,
    output fp_flags_t            flags
);

    localparam logic [63:0] QNAN_L = qnan(EXP_W, MAN_W);
    localparam logic [W-1:0] QNAN = QNAN_L[W-1:0];
    localparam logic signed [XW-1:0] E_TOP = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] E_ZERO = '0;

    logic [PW-1:0]        pn;
    logic [MAN_W:0]       sig;
    logic [MAN_W-1:0]     frac;
    logic signed [XW-1:0] e1;
    logic signed [XW-1:0] e2;

    // Product of two [1,2) significands lies in [1,4): at most one right shift.
    assign pn  = prod[PW-1] ? prod : (prod << 1);
    assign e1  = esum + $signed({{(XW-1){1'b0}}, prod[PW-1]});
    assign sig = pn[PW-1:MAN_W+1];

`ifdef FP_MUL_RNE_EN
    logic           guard_bit;
    logic           round_bit;
    logic           sticky_bit;
    logic           inc;
    logic [MAN_W+1:0] sum;

    assign guard_bit  = pn[MAN_W];
    assign round_bit  = pn[MAN_W-1];
    assign sticky_bit = |pn[MAN_W-2:0];
    assign inc  = guard_bit & (round_bit | sticky_bit | sig[0]);
    assign sum  = {1'b0, sig} + {{(MAN_W+1){1'b0}}, inc};
    // A carry out leaves 10.00..0, so the fraction is zero either way.
    assign frac = sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0];
    assign e2   = e1 + $signed({{(XW-1){1'b0}}, sum[MAN_W+1]});
`else
    logic unused_bits;

    assign unused_bits = ^{sig[MAN_W], pn[MAN_W:0]};
    assign frac = sig[MAN_W-1:0];
    assign e2   = e1;
`endif

    always_comb begin
        y     = '0;
        flags = '0;
        case (cls)
            FP_NAN: begin
                y             = QNAN;
                flags.invalid = 1'b1;
            end
            FP_INF:  y = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            FP_ZERO: y = {sign, {(W-1){1'b0}}};
            default: begin
                if (e2 >= E_TOP) begin
                    y              = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags.overflow = 1'b1;
                end else if (e2 <= E_ZERO) begin
                    y               = {sign, {(W-1){1'b0}}};
                    flags.underflow = 1'b1;
                end else begin
                    y = {sign, e2[EXP_W-1:0], frac};
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready streaming.
// Optional macro FP_MUL_RNE_EN selects round-to-nearest-even instead of truncation.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         flag_invalid,
    output logic         flag_overflow,
    output logic         flag_underflow
);

    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam logic [XW-1:0] BIAS_X = XW'(bias(EXP_W));

    // Handshake: a word moves on a rising edge where valid && ready; the whole
    // pipe advances together whenever the output slot is empty or being taken.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0)      return FP_ZERO;
        else if (e == '1) return (f == '0) ? FP_INF : FP_NAN;
        else              return FP_NORM;
    endfunction

    fp_class_e ca, cb, c1_next;
    logic [XW-1:0] esum_next;

    assign ca = classify(a[W-2:MAN_W], a[MAN_W-1:0]);
    assign cb = classify(b[W-2:MAN_W], b[MAN_W-1:0]);
    assign esum_next = {2'b00, a[W-2:MAN_W]} + {2'b00, b[W-2:MAN_W]} - BIAS_X;

    // Special-value precedence resolved once, up front.
    always_comb begin
        c1_next = FP_NORM;
        if (ca == FP_NAN || cb == FP_NAN || (ca == FP_INF && cb == FP_ZERO) ||
            (ca == FP_ZERO && cb == FP_INF))
            c1_next = FP_NAN;
        else if (ca == FP_INF || cb == FP_INF)
            c1_next = FP_INF;
        else if (ca == FP_ZERO || cb == FP_ZERO)
            c1_next = FP_ZERO;
    end

    logic                 s1_valid, s1_sign;
    fp_class_e            s1_cls;
    logic signed [XW-1:0] s1_esum;
    logic [MAN_W:0]       s1_ma, s1_mb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_cls   <= FP_ZERO;
            s1_esum  <= '0;
            s1_ma    <= '0;
            s1_mb    <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_sign  <= a[W-1] ^ b[W-1];
            s1_cls   <= c1_next;
            s1_esum  <= esum_next;
            s1_ma    <= {1'b1, a[MAN_W-1:0]};
            s1_mb    <= {1'b1, b[MAN_W-1:0]};
        end
    end

    logic                 s2_valid, s2_sign;
    fp_class_e            s2_cls;
    logic signed [XW-1:0] s2_esum;
    logic [PW-1:0]        s2_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_cls   <= FP_ZERO;
            s2_esum  <= '0;
            s2_prod  <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_cls   <= s1_cls;
            s2_esum  <= s1_esum;
            s2_prod  <= PW'(s1_ma) * PW'(s1_mb);
        end
    end

    logic [W-1:0] y_next;
    fp_flags_t    flags_next, out_flags;

    fp_mul_norm_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_norm_round (
        .sign  (s2_sign),
        .cls   (s2_cls),
        .esum  (s2_esum),
        .prod  (s2_prod),
        .y     (y_next),
        .flags (flags_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            out_flags <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            y         <= y_next;
            out_flags <= flags_next;
        end
    end

    assign flag_invalid   = out_flags.invalid;
    assign flag_overflow  = out_flags.overflow;
    assign flag_underflow = out_flags.underflow;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (binary32): directed cases, random traffic
// with stalls and bubbles, back-pressure and mid-stream reset.
module tb_fp_mul_pipe;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [34:0] exp;
    } stim_t;

    logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, y;
    logic        flag_invalid, flag_overflow, flag_underflow;

    fp_mul_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
        .flag_underflow(flag_underflow)
    );

    stim_t       stim_q[$];
    logic [34:0] exp_q[$];
    int          out_cyc_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          accepted = 0;
    bit          rdy_rand = 0;
    bit          bub_rand = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [34:0] mk(input logic [31:0] yv, input logic inv, input logic ovf, input logic unf);
        return {yv, inv, ovf, unf};
    endfunction

    // ---------------- reference model ----------------
    // Exact integer product of significands, then normalise by locating the
    // leading one and rounding the discarded remainder.
    function automatic logic [34:0] ref_mul(input logic [31:0] x, input logic [31:0] z);
        int ex, ez, n, k, e;
        logic sx, sz, s, zx, zz, ix, iz, nx, nz;
        longint unsigned fx, fz, p, q, rem, one;
        sx = x[31]; sz = z[31]; s = sx ^ sz;
        ex = int'(x[30:23]); ez = int'(z[30:23]);
        fx = 64'(x[22:0]); fz = 64'(z[22:0]);
        zx = (ex == 0); zz = (ez == 0);
        ix = (ex == 255) && (fx == 0); iz = (ez == 255) && (fz == 0);
        nx = (ex == 255) && (fx != 0); nz = (ez == 255) && (fz != 0);
        if (nx || nz || (ix && zz) || (zx && iz)) return mk(32'h7FC00000, 1, 0, 0);
        if (ix || iz) return mk({s, 8'hFF, 23'h0}, 0, 0, 0);
        if (zx || zz) return mk({s, 31'h0}, 0, 0, 0);
        one = 1;
        p = (fx | (one << 23)) * (fz | (one << 23));
        n = 63;
        while (p[n] == 1'b0) n--;
        k = n - 23;
        q = p >> k;
        rem = p & ((one << k) - 1);
`ifdef FP_MUL_RNE_EN
        if (rem > (one << (k - 1)) || (rem == (one << (k - 1)) && q[0])) q++;
        if (q == (one << 24)) begin
            q = q >> 1;
            n++;
        end
`else
        if (rem > q) rem = 0;
`endif
        e = ex + ez - 127 + (n - 46);
        if (e >= 255) return mk({s, 8'hFF, 23'h0}, 0, 1, 0);
        if (e <= 0) return mk({s, 31'h0}, 0, 0, 1);
        return mk({s, e[7:0], q[22:0]}, 0, 0, 0);
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int m;
        v = $urandom;
        m = $urandom_range(0, 11);
        if (m == 0) v[30:23] = 8'h00;
        else if (m == 1) begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
        else if (m == 2) v[30:23] = 8'hFF;
        else if (m == 3) v[30:23] = 8'(128 + $urandom_range(60, 126));
        else if (m == 4) v[30:23] = 8'($urandom_range(1, 66));
        else v[30:23] = 8'($urandom_range(1, 254));
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic push(input logic [31:0] x, input logic [31:0] z, input logic [34:0] e);
        stim_t t;
        t.a = x; t.b = z; t.exp = e;
        stim_q.push_back(t);
    endtask

    task automatic push_rand();
        logic [31:0] x, z;
        x = rand_op();
        z = rand_op();
        push(x, z, ref_mul(x, z));
    endtask

    initial begin
        bit stalled;
        stalled = 0;
        in_valid = 1'b0; a = '0; b = '0;
        forever begin
            @(negedge clk);
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
            if (stim_q.size() > 0 && (stalled || !(bub_rand && $urandom_range(0, 3) == 0))) begin
                in_valid = 1'b1;
                a = stim_q[0].a;
                b = stim_q[0].b;
            end else begin
                in_valid = 1'b0;
            end
            #4;
            stalled = 0;
            if (!rst && in_valid && stim_q.size() > 0) begin
                if (in_ready) begin
                    exp_q.push_back(stim_q[0].exp);
                    void'(stim_q.pop_front());
                    accepted++;
                end else begin
                    stalled = 1;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit          hold_v;
        logic [34:0] hold_val;
        hold_v = 0;
        hold_val = '0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                hold_v = 0;
            end else begin
                if (hold_v)
                    chk("hold_stable", {out_valid, y, flag_invalid, flag_overflow, flag_underflow},
                        {1'b1, hold_val});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0)
                        chk("unexpected_output", {1'b1, y}, 33'h0);
                    else
                        chk("result", {y, flag_invalid, flag_overflow, flag_underflow}, exp_q.pop_front());
                    out_cyc_q.push_back(cyc);
                    hold_v = 0;
                end else if (out_valid) begin
                    hold_v = 1;
                    hold_val = {y, flag_invalid, flag_overflow, flag_underflow};
                end else begin
                    hold_v = 0;
                end
            end
        end
    end

    task automatic drain();
        int t;
        t = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk("drain_timeout", 64'(t >= 3000), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base, t, qs;
        bit stale;
        rst = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_y", 64'(y), 0);
        chk("rst_flags", 64'({flag_invalid, flag_overflow, flag_underflow}), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        // Latency: result visible after the third rising edge counting acceptance.
        base = accepted;
        push(32'h3FC00000, 32'h40000000, mk(32'h40400000, 0, 0, 0));
        t = 0;
        while (accepted == base && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("accept_timeout", 64'(t >= 100), 0);
        @(posedge clk); #1;
        chk("lat_not_early", 64'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_3", 64'(out_valid), 1);
        drain();

        // Back-to-back: outputs on consecutive cycles.
        out_cyc_q.delete();
        push(32'h40400000, 32'h3F800000, mk(32'h40400000, 0, 0, 0));
        push(32'h3F800000, 32'h3F800000, mk(32'h3F800000, 0, 0, 0));
        push(32'h00000000, 32'h3F800000, mk(32'h00000000, 0, 0, 0));
        drain();
        qs = out_cyc_q.size();
        chk("b2b_count", 64'(qs), 3);
        if (qs == 3) begin
            chk("b2b_gap1", 64'(out_cyc_q[1] - out_cyc_q[0]), 1);
            chk("b2b_gap2", 64'(out_cyc_q[2] - out_cyc_q[1]), 1);
        end

        // Specials, range and rounding.
        push(32'h7F800000, 32'h3F800000, mk(32'h7F800000, 0, 0, 0));
        push(32'h7F800000, 32'h00000000, mk(32'h7FC00000, 1, 0, 0));
        push(32'hBF800000, 32'h00000000, mk(32'h80000000, 0, 0, 0));
        push(32'h7FC12345, 32'h3F800000, mk(32'h7FC00000, 1, 0, 0));
        push(32'h00400000, 32'h40000000, mk(32'h00000000, 0, 0, 0));
        push(32'h7F000000, 32'h7F000000, mk(32'h7F800000, 0, 1, 0));
        push(32'h00800000, 32'h00800000, mk(32'h00000000, 0, 0, 1));
`ifdef FP_MUL_RNE_EN
        push(32'h3FC00001, 32'h3FC00001, mk(32'h40100002, 0, 0, 0));
`else
        push(32'h3FC00001, 32'h3FC00001, mk(32'h40100001, 0, 0, 0));
`endif
        drain();

        // Back-pressure: three accepted, then in_ready low; all six emerge in order.
        @(negedge clk);
        out_ready = 1'b0;
        base = accepted;
        out_cyc_q.delete();
        repeat (6) push_rand();
        repeat (8) @(posedge clk);
        #1;
        chk("bp_accepted", 64'(accepted - base), 3);
        chk("bp_in_ready", 64'(in_ready), 0);
        @(negedge clk);
        out_ready = 1'b1;
        drain();
        chk("bp_out_count", 64'(out_cyc_q.size()), 6);

        // Random traffic with random back-pressure and bubbles.
        rdy_rand = 1;
        bub_rand = 1;
        repeat (400) push_rand();
        drain();
        rdy_rand = 0;
        bub_rand = 0;
        @(negedge clk);
        out_ready = 1'b1;

        // Reset mid-stream.
        out_ready = 1'b0;
        repeat (6) push_rand();
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 0);
        chk("midrst_in_ready", 64'(in_ready), 1);
        stim_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            #4;
            if (out_valid) stale = 1;
        end
        chk("no_stale_after_rst", 64'(stale), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
